counter_uart_tx: RTL

COUNTER_UART_TX -- requirements
Module: counter_uart_tx

---
 rtl/counter_uart_pkg.sv | 28 ++
 rtl/counter_uart_tx_baud_gen.sv | 31 +++
 rtl/counter_uart_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/counter_uart_pkg.sv
// Shared types and constants for the counter UART transmitter.
// Build with UART_PARITY_EN defined to add an even-parity bit after the data bits.
package counter_uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam int   BIT_IDX_W  = 3;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
`ifdef UART_PARITY_EN
        ,
        ST_PARITY = 3'd3
`endif
    } uart_state_e;

`ifdef UART_PARITY_EN
    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/counter_uart_tx_baud_gen.sv
// Bit-period timer: tick is high for one cycle out of every CLKS_PER_BIT.
// clear restarts the period so the first tick lands CLKS_PER_BIT cycles later.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_uart_tx.sv
// Serialises one byte per accepted valid_in/ready_out handshake onto a UART line (8N1, or 8E1
// with UART_PARITY_EN). Handshake: a byte transfers on a rising edge where valid_in and
// ready_out are both high; ready_out is high only in IDLE and valid_in is ignored otherwise.
module counter_uart_tx
    import counter_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy,
    output logic [STATE_W-1:0]   o_dbg_state
);

    uart_state_e            r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic                   r_tx;
`ifdef UART_PARITY_EN
    logic                   r_parity;
`endif

    logic w_accept;
    logic w_tick;

    assign w_accept    = valid_in && (r_state == ST_IDLE);
    assign ready_out   = (r_state == ST_IDLE);
    assign busy        = ~ready_out;
    assign tx          = r_tx;
    assign o_dbg_state = r_state;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(w_accept),
        .tick (w_tick)
    );

    // tx is updated together with the state so every bit boundary coincides with a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= IDLE_LEVEL;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= IDLE_LEVEL;
                    if (w_accept) begin
                        r_shift   <= data_in;
                        r_bit_idx <= '0;
                        r_tx      <= ~IDLE_LEVEL;
`ifdef UART_PARITY_EN
                        r_parity  <= even_parity(data_in);
`endif
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= IDLE_LEVEL;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end

`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= IDLE_LEVEL;
                        r_state <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_tick) begin
                        r_tx    <= IDLE_LEVEL;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
